// File: rtl/cdc_fifo_write_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full/almost-full/fill-level. Optional sticky overflow: CDC_FIFO_OVERFLOW_FLAG_EN.
module cdc_fifo_write_ctrl #(
  parameter int ADDRESS_WIDTH     = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int ALMOST_FULL_LEVEL = (1 << ADDRESS_WIDTH) - 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     write_request,
  input  logic [ADDRESS_WIDTH:0]   read_pointer_gray,
  input  logic                     clear_overflow,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH:0]   fill_level,
  output logic                     overflow
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rsync_q [SYNC_STAGES];
  logic [PW-1:0] rsync_d [SYNC_STAGES];
  logic [PW-1:0] rptr_sync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_match;
  logic          full_q, full_d;
  logic          accept;

  genvar gi;

  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_rsync
      if (gi == 0) begin : g_first
        assign rsync_d[gi] = read_pointer_gray;
      end else begin : g_rest
        assign rsync_d[gi] = rsync_q[gi-1];
      end
    end
  endgenerate

  assign rptr_sync = rsync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (gi = 0; gi < PW; gi++) begin : g_g2b
      assign rbin[gi] = ^(rptr_sync >> gi);
    end
  endgenerate

  always_comb begin
    accept     = write_request & ~full_q;
    wbin_d     = wbin_q + PW'(accept);
    wgray_d    = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer has lapped the read pointer by exactly one depth.
    full_match = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
    full_d     = (wgray_d == full_match);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rsync_q[i] <= '0;
      end
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rsync_q[i] <= rsync_d[i];
      end
    end
  end

  assign write_enable       = accept;
  assign write_address      = wbin_q[ADDRESS_WIDTH-1:0];
  assign write_pointer_gray = wgray_q;
  assign full               = full_q;
  assign fill_level         = wbin_q - rbin;
  assign almost_full        = (fill_level >= AF_LEVEL);

`ifdef CDC_FIFO_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // A dropped request wins over a clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (write_request & full_q) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_clear_overflow;
  assign unused_clear_overflow = clear_overflow;
  assign overflow = 1'b0;
`endif

endmodule
